// File: rtl/n4_sched_pkg.sv
// rtl/n4_sched_pkg.sv - shared FSM encoding and default sizing for the n4_sched block
// Contents: state_e (IDLE/RUN/DRAIN/DONE) and default N, ADDR_SIZE, CMPR_LAT, FIFO_DEPTH.
package n4_sched_pkg;

    localparam int N_DEF          = 16;
    localparam int ADDR_SIZE_DEF  = 16;
    localparam int CMPR_LAT_DEF   = 1;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/n4_sched_if.sv
// rtl/n4_sched_if.sv - result stream interface (FIFO head toward the consumer)
// Signals: out_valid, out_ready, out_f_addr[ADDR_SIZE], out_offset[N].
// Modports: master drives valid/data and samples ready; slave is the consumer side.
interface n4_sched_if
    import n4_sched_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) ();

    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_SIZE-1:0] out_f_addr;
    logic [N-1:0]         out_offset;

    modport master (output out_valid, output out_f_addr, output out_offset, input out_ready);
    modport slave  (input out_valid, input out_f_addr, input out_offset, output out_ready);

endinterface

// File: rtl/n4_sched_fifo.sv
// rtl/n4_sched_fifo.sv - first-word-fall-through result FIFO
// Ports: clk, rst (async, active-high); push_i/push_data_i write side;
//   count_o occupancy; out_valid_o/out_ready_i/out_data_o read side (head shown while valid, else 0).
module n4_sched_fifo
    import n4_sched_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_data_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pop, wr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_valid_o = (cnt_q != '0);
    assign out_data_o  = out_valid_o ? mem_q[rd_q] : '0;
    assign count_o     = cnt_q;
    assign pop         = out_valid_o && out_ready_i;
    // A full FIFO still takes a push when its head leaves in the same cycle.
    assign wr          = push_i && ((cnt_q != CW'(DEPTH)) || pop);

    always_comb begin
        wr_d  = wr  ? ptr_next(wr_q) : wr_q;
        rd_d  = pop ? ptr_next(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(wr) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/n4_sched.sv
// rtl/n4_sched.sv - job scheduler: SRAM reads -> external compressor -> result FIFO
// Ports: clk, rst (async, active-high); start/base_addr/len job request; busy/done status;
//   sram_rd_en/sram_addr/sram_rdata read port (data one cycle after strobe);
//   cmpr_valid/cmpr_data/cmpr_base_addr to compressor, cmpr_f_addr/cmpr_offset back after CMPR_LAT;
//   out_if (master) result stream out_valid/out_ready/out_f_addr/out_offset.
// Config macro: N4_SCHED_SKIP_ZERO_EN - zero words are not sent to the compressor and yield no result.
module n4_sched
    import n4_sched_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int ADDR_SIZE  = ADDR_SIZE_DEF,
    parameter int CMPR_LAT   = CMPR_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [ADDR_SIZE-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 sram_rd_en,
    output logic [ADDR_SIZE-1:0] sram_addr,
    input  logic [N-1:0]         sram_rdata,
    output logic                 cmpr_valid,
    output logic [N-1:0]         cmpr_data,
    output logic [ADDR_SIZE-1:0] cmpr_base_addr,
    input  logic [ADDR_SIZE-1:0] cmpr_f_addr,
    input  logic [N-1:0]         cmpr_offset,
    n4_sched_if.master           out_if
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(FIFO_DEPTH + CMPR_LAT + 2) + 1;

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] base_q, base_d, len_q, len_d, idx_q, idx_d;
    logic                 rd_vld_q;
    logic [ADDR_SIZE-1:0] rd_addr_q;
    logic [CMPR_LAT-1:0]  lat_q, lat_d;
    logic                 done_q;

    logic [CW-1:0]          fifo_count;
    logic                   fifo_valid;
    logic [ADDR_SIZE+N-1:0] fifo_data;
    logic [OW-1:0]          occ;
    logic                   issue, word_fwd, pipe_idle;
    logic [ADDR_SIZE-1:0]   rd_addr;

    assign rd_addr = base_q + idx_q;

    // Occupancy reserves a FIFO slot for every word between read issue and push,
    // so a new read is only issued when its result is guaranteed a place.
    always_comb begin
        occ = OW'(fifo_count) + OW'(rd_vld_q);
        for (int k = 0; k < CMPR_LAT; k++) begin
            occ = occ + OW'(lat_q[k]);
        end
    end

    assign issue     = (state_q == S_RUN) && (occ < OW'(FIFO_DEPTH));
    assign pipe_idle = !rd_vld_q && (lat_q == '0);

    assign sram_rd_en = issue;
    assign sram_addr  = issue ? rd_addr : '0;

`ifdef N4_SCHED_SKIP_ZERO_EN
    // A zero word ends here: its slot is released as rd_vld_q drops next cycle.
    assign word_fwd = rd_vld_q && (sram_rdata != '0);
`else
    assign word_fwd = rd_vld_q;
`endif

    assign cmpr_valid     = word_fwd;
    assign cmpr_data      = word_fwd ? sram_rdata : '0;
    assign cmpr_base_addr = word_fwd ? rd_addr_q : '0;

    // lat_q[k] marks a word k+1 cycles past cmpr_valid; the last stage is
    // the cycle the compressor result is valid and gets pushed.
    always_comb begin
        lat_d    = '0;
        lat_d[0] = word_fwd;
        for (int k = 1; k < CMPR_LAT; k++) begin
            lat_d[k] = lat_q[k-1];
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = len;
                    idx_d   = '0;
                    state_d = (len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (issue) begin
                    idx_d = idx_q + ADDR_SIZE'(1);
                    if (idx_d == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pipe_idle && (fifo_count == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            lat_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rd_vld_q  <= issue;
            rd_addr_q <= rd_addr;
            lat_q     <= lat_d;
            done_q    <= (state_q == S_DONE);
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

    n4_sched_fifo #(
        .WIDTH (ADDR_SIZE + N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (lat_q[CMPR_LAT-1]),
        .push_data_i ({cmpr_f_addr, cmpr_offset}),
        .count_o     (fifo_count),
        .out_valid_o (fifo_valid),
        .out_ready_i (out_if.out_ready),
        .out_data_o  (fifo_data)
    );

    assign out_if.out_valid  = fifo_valid;
    assign out_if.out_f_addr = fifo_data[N +: ADDR_SIZE];
    assign out_if.out_offset = fifo_data[N-1:0];

endmodule
